// File: rtl/minc_boot_loader_if.sv
// Byte-stream and instruction-ROM write bus of the boot loader.
// The loader is the slave: it takes bytes and drives the ROM write strobe.
interface minc_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rom_we;
    logic [7:0]  rom_addr;
    logic [14:0] rom_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  rom_we,
        input  rom_addr,
        input  rom_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output rom_we,
        output rom_addr,
        output rom_wdata
    );
endinterface

// File: rtl/minc_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed image over a byte
// stream, writes it into the instruction ROM and releases the CPU on success.
// Image format: N, then N x {lo, hi}, then a checksum byte; N=0 means 256 words.
module minc_boot_loader #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic                start,
    minc_boot_loader_if.slave   bus,
    output logic                cpu_nreset,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StLen, StLo, StHi, StWr, StCsum, StRun, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        csum_q, csum_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [7:0]        rom_addr_q, rom_addr_d;
    logic [14:0]       rom_wdata_q, rom_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_nreset_q, cpu_nreset_d;

    logic              rx_ready;
    logic              accept;
    logic [7:0]        sum_next;
    logic              timed_out;

    assign rx_ready  = (state_q == StLen) || (state_q == StLo) ||
                       (state_q == StHi)  || (state_q == StCsum);
    assign accept    = bus.rx_valid && rx_ready;
    assign sum_next  = csum_q + bus.rx_data;
    assign timed_out = (TIMEOUT != 0) && rx_ready && !accept && (idle_q == IdleLast);

    assign bus.rx_ready  = rx_ready;
    assign bus.rom_we    = (state_q == StWr);
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_wdata = rom_wdata_q;
    assign cpu_nreset    = cpu_nreset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    // Next-state, datapath and registered-status decode.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        csum_d      = csum_q;
        idle_d      = idle_q;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        if (rx_ready) begin
            idle_d = (TIMEOUT == 0 || accept) ? '0 : idle_q + 1'b1;
        end
        if (accept) begin
            csum_d = sum_next;
        end

        case (state_q)
            StIdle, StRun, StErr: begin
                if (start) begin
                    state_d    = StLen;
                    idx_d      = 8'h00;
                    rom_addr_d = 8'h00;
                    csum_d     = 8'h00;
                    idle_d     = '0;
                end
            end
            StLen: begin
                if (accept) begin
                    n_d     = bus.rx_data;
                    state_d = StLo;
                end
            end
            StLo: begin
                if (accept) begin
                    lo_d    = bus.rx_data;
                    state_d = StHi;
                end
            end
            StHi: begin
                // Load the ROM bus on entry to WR so it only moves with rom_we.
                if (accept) begin
                    rom_wdata_d = {bus.rx_data[6:0], lo_q};
                    rom_addr_d  = idx_q;
                    state_d     = StWr;
                end
            end
            StWr: begin
                // 8-bit wrap makes N=0 finish after 256 words.
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q + 8'd1 == n_q) ? StCsum : StLo;
            end
            StCsum: begin
                if (accept) begin
                    state_d = (sum_next == 8'h00) ? StRun : StErr;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timed_out) begin
            state_d = StErr;
        end

        busy_d       = (state_d == StLen) || (state_d == StLo) || (state_d == StHi) ||
                       (state_d == StWr)  || (state_d == StCsum);
        done_d       = (state_d == StRun);
        err_d        = (state_d == StErr);
        cpu_nreset_d = (state_d == StRun);
    end

    // State and datapath registers, cleared asynchronously by nRESET.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= StIdle;
            n_q          <= 8'h00;
            idx_q        <= 8'h00;
            lo_q         <= 8'h00;
            csum_q       <= 8'h00;
            idle_q       <= '0;
            rom_addr_q   <= 8'h00;
            rom_wdata_q  <= 15'h0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_nreset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            lo_q         <= lo_d;
            csum_q       <= csum_d;
            idle_q       <= idle_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_nreset_q <= cpu_nreset_d;
        end
    end

endmodule

// File: tb/tb_minc_boot_loader.sv
// Directed bench for minc_boot_loader: reset, good and bad images, 256-word
// image, high-bit masking, backpressure, timeout/restart and mid-load reset.
module tb_minc_boot_loader;

    logic CLK;
    logic nRESET;
    logic start;
    logic cpu_nreset;
    logic busy;
    logic done;
    logic err;

    int n_checks = 0;
    int n_fail   = 0;

    minc_boot_loader_if bus ();

    minc_boot_loader #(
        .TIMEOUT (16)
    ) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .start      (start),
        .bus        (bus.slave),
        .cpu_nreset (cpu_nreset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [14:0] wd;
        logic        bsy;
        logic        dn;
        logic        er;
        logic        nr;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic st, input logic vld, input logic [7:0] dat,
                                input logic rdy, input logic we, input logic [7:0] addr,
                                input logic [14:0] wd, input logic bsy, input logic dn,
                                input logic er, input logic nr);
        vec_t v;
        v.st = st; v.vld = vld; v.dat = dat; v.rdy = rdy; v.we = we; v.addr = addr;
        v.wd = wd; v.bsy = bsy; v.dn = dn; v.er = er; v.nr = nr;
        return v;
    endfunction

    // Observed outputs: {rx_ready, rom_we, rom_addr, rom_wdata, busy, done, err, cpu_nreset}
    function automatic logic [31:0] outs();
        return 32'({bus.rx_ready, bus.rom_we, bus.rom_addr, bus.rom_wdata,
                    busy, done, err, cpu_nreset});
    endfunction

    function automatic logic [31:0] exp_of(input vec_t v);
        return 32'({v.rdy, v.we, v.addr, v.wd, v.bsy, v.dn, v.er, v.nr});
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a byte until accepted; bounded wait.
    task automatic send_byte(input logic [7:0] d);
        logic acc;
        acc = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = bus.rx_ready;
            tick();
        end
        bus.rx_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_byte %h: got no acceptance, expected acceptance", d);
        end
    endtask

    initial begin
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] sum;
        logic       saw_we;

        // Good image, with a CSUM byte presented during WR (must be held).
        vecs[0]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 15'h0000, 1, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'h02, 1, 0, 8'h00, 15'h0000, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 8'h34, 1, 0, 8'h00, 15'h0000, 1, 0, 0, 0);
        vecs[3]  = mk(0, 1, 8'h12, 0, 1, 8'h00, 15'h1234, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 15'h1234, 1, 0, 0, 0);
        vecs[5]  = mk(0, 1, 8'hCD, 1, 0, 8'h00, 15'h1234, 1, 0, 0, 0);
        vecs[6]  = mk(0, 1, 8'h2B, 0, 1, 8'h01, 15'h2BCD, 1, 0, 0, 0);
        vecs[7]  = mk(0, 1, 8'hC0, 1, 0, 8'h01, 15'h2BCD, 1, 0, 0, 0);
        vecs[8]  = mk(0, 1, 8'hC0, 0, 0, 8'h01, 15'h2BCD, 0, 1, 0, 1);
        vecs[9]  = mk(0, 0, 8'h00, 0, 0, 8'h01, 15'h2BCD, 0, 1, 0, 1);
        // Restart from RUN, same image with bad checksum C1; LO byte held across WR.
        vecs[10] = mk(1, 0, 8'h00, 1, 0, 8'h00, 15'h2BCD, 1, 0, 0, 0);
        vecs[11] = mk(0, 1, 8'h02, 1, 0, 8'h00, 15'h2BCD, 1, 0, 0, 0);
        vecs[12] = mk(0, 1, 8'h34, 1, 0, 8'h00, 15'h2BCD, 1, 0, 0, 0);
        vecs[13] = mk(0, 1, 8'h12, 0, 1, 8'h00, 15'h1234, 1, 0, 0, 0);
        vecs[14] = mk(0, 1, 8'hCD, 1, 0, 8'h00, 15'h1234, 1, 0, 0, 0);
        vecs[15] = mk(0, 1, 8'hCD, 1, 0, 8'h00, 15'h1234, 1, 0, 0, 0);
        vecs[16] = mk(0, 1, 8'h2B, 0, 1, 8'h01, 15'h2BCD, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 8'h00, 1, 0, 8'h01, 15'h2BCD, 1, 0, 0, 0);
        vecs[18] = mk(0, 1, 8'hC1, 0, 0, 8'h01, 15'h2BCD, 0, 0, 1, 0);
        vecs[19] = mk(0, 0, 8'h00, 0, 0, 8'h01, 15'h2BCD, 0, 0, 1, 0);

        // Reset: 3 cycles low with rx_valid high, then release.
        nRESET       = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        tick(); tick(); tick();
        check("in_reset", outs(), 32'h0);
        nRESET = 1'b1;
        tick();
        check("after_release", outs(), 32'h0);
        tick();
        check("idle_ignores_valid", outs(), 32'h0);
        bus.rx_valid = 1'b0;

        // Table-driven vectors: good load, then bad checksum.
        for (int i = 0; i < 20; i++) begin
            start        = vecs[i].st;
            bus.rx_valid = vecs[i].vld;
            bus.rx_data  = vecs[i].dat;
            tick();
            start = 1'b0;
            check($sformatf("vec%0d", i), outs(), exp_of(vecs[i]));
        end
        bus.rx_valid = 1'b0;

        // High-bit masking: N=1, lo=00, hi=92 -> 0x1200; csum 6D.
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h92);
        check("hibit_word", 32'({bus.rom_we, bus.rom_addr, bus.rom_wdata}),
              32'({1'b1, 8'h00, 15'h1200}));
        send_byte(8'h6D);
        check("hibit_done", 32'({busy, done, err, cpu_nreset}), 32'b0101);

        // 256-word image: lo=i, hi=~i.
        do_start();
        send_byte(8'h00);
        sum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            lo = 8'(i);
            hi = ~lo;
            send_byte(lo);
            send_byte(hi);
            sum = sum + lo + hi;
            check($sformatf("w256_%0d", i), 32'({bus.rom_we, bus.rom_addr, bus.rom_wdata}),
                  32'({1'b1, lo, hi[6:0], lo}));
        end
        tick();
        check("w256_csum_state", 32'({bus.rx_ready, bus.rom_we, bus.rom_addr, busy, done}),
              32'({1'b1, 1'b0, 8'hFF, 1'b1, 1'b0}));
        send_byte(8'h00 - sum);
        check("w256_done", 32'({busy, done, err, cpu_nreset}), 32'b0101);

        // Timeout: stall 16 cycles in HI after the LO byte.
        do_start();
        check("restart_from_run", 32'({busy, done, cpu_nreset}), 32'b100);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 15; i++) tick();
        check("timeout_pre", 32'({busy, err}), 32'b10);
        tick();
        check("timeout_err", 32'({busy, done, err, cpu_nreset}), 32'b0010);
        tick();
        check("err_held", 32'({busy, done, err, cpu_nreset}), 32'b0010);
        do_start();
        check("restart_from_err", 32'({busy, err}), 32'b10);

        // Mid-load reset: abort in HI with the hi byte presented.
        send_byte(8'h01);
        send_byte(8'h00);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h92;
        #2;
        nRESET = 1'b0;
        #1;
        check("async_abort", outs(), 32'h0);
        saw_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_we = saw_we | bus.rom_we;
        end
        nRESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_we = saw_we | bus.rom_we;
        end
        check("no_we_after_abort", 32'(saw_we), 32'h0);
        check("idle_after_abort", outs(), 32'h0);
        bus.rx_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
